// File: rtl/mem_arb_if.sv
// Bus bundle for mem_arb: two client ports (A read/write, B read-only) and the memory port.
// The arbiter uses the slave view; clients and memory together form the master view.
interface mem_arb_if #(
  parameter int AW = 20,
  parameter int DW = 32
);
  logic          areq;
  logic [AW-1:0] aaddr;
  logic          awr;
  logic [DW-1:0] awdata;
  logic          aack;
  logic [DW-1:0] ardata;

  logic          breq;
  logic [AW-1:0] baddr;
  logic          back;
  logic [DW-1:0] brdata;

  logic          memreq;
  logic [AW-1:0] memaddr;
  logic          memwr;
  logic [DW-1:0] memwdata;
  logic          memack;
  logic [DW-1:0] memrdata;

  modport slave (
    input  areq, aaddr, awr, awdata, breq, baddr, memack, memrdata,
    output aack, ardata, back, brdata, memreq, memaddr, memwr, memwdata
  );

  modport master (
    output areq, aaddr, awr, awdata, breq, baddr, memack, memrdata,
    input  aack, ardata, back, brdata, memreq, memaddr, memwr, memwdata
  );
endinterface

// File: rtl/mem_arb.sv
// Two-port memory arbiter with round-robin grant and a one-entry read cache per port.
// Port A may write (write-through, keeps B's cache coherent); port B only reads.
//
// state | meaning
// IDLE  | pick one eligible request; hit -> ACK, miss/write -> MEM
// MEM   | memory transaction outstanding, waiting for memack
// ACK   | granted port's ack pulse is high; grant pointer updates
module mem_arb #(
  parameter int AW       = 20,
  parameter int DW       = 32,
  parameter int CACHE_EN = 1
) (
  input logic      clk,
  input logic      rst,
  mem_arb_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          gnt_b_q, gnt_b_d;
  logic          last_b_q, last_b_d;
  logic          just_q, just_d;

  logic          aack_q, aack_d;
  logic          back_q, back_d;
  logic [DW-1:0] ardata_q, ardata_d;
  logic [DW-1:0] brdata_q, brdata_d;

  logic          memreq_q, memreq_d;
  logic [AW-1:0] memaddr_q, memaddr_d;
  logic          memwr_q, memwr_d;
  logic [DW-1:0] memwdata_q, memwdata_d;

  logic          a_vld_q, a_vld_d;
  logic [AW-1:0] a_tag_q, a_tag_d;
  logic [DW-1:0] a_dat_q, a_dat_d;
  logic          b_vld_q, b_vld_d;
  logic [AW-1:0] b_tag_q, b_tag_d;
  logic [DW-1:0] b_dat_q, b_dat_d;

  logic          elig_a, elig_b, pick_b, sel_wr, hit;
  logic [AW-1:0] sel_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gnt_b_q    <= 1'b0;
      last_b_q   <= 1'b0;
      just_q     <= 1'b0;
      aack_q     <= 1'b0;
      back_q     <= 1'b0;
      ardata_q   <= '0;
      brdata_q   <= '0;
      memreq_q   <= 1'b0;
      memaddr_q  <= '0;
      memwr_q    <= 1'b0;
      memwdata_q <= '0;
      a_vld_q    <= 1'b0;
      a_tag_q    <= '0;
      a_dat_q    <= '0;
      b_vld_q    <= 1'b0;
      b_tag_q    <= '0;
      b_dat_q    <= '0;
    end else begin
      state_q    <= state_d;
      gnt_b_q    <= gnt_b_d;
      last_b_q   <= last_b_d;
      just_q     <= just_d;
      aack_q     <= aack_d;
      back_q     <= back_d;
      ardata_q   <= ardata_d;
      brdata_q   <= brdata_d;
      memreq_q   <= memreq_d;
      memaddr_q  <= memaddr_d;
      memwr_q    <= memwr_d;
      memwdata_q <= memwdata_d;
      a_vld_q    <= a_vld_d;
      a_tag_q    <= a_tag_d;
      a_dat_q    <= a_dat_d;
      b_vld_q    <= b_vld_d;
      b_tag_q    <= b_tag_d;
      b_dat_q    <= b_dat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_b_d    = gnt_b_q;
    last_b_d   = last_b_q;
    just_d     = 1'b0;
    aack_d     = 1'b0;
    back_d     = 1'b0;
    ardata_d   = ardata_q;
    brdata_d   = brdata_q;
    memreq_d   = memreq_q;
    memaddr_d  = memaddr_q;
    memwr_d    = memwr_q;
    memwdata_d = memwdata_q;
    a_vld_d    = a_vld_q;
    a_tag_d    = a_tag_q;
    a_dat_d    = a_dat_q;
    b_vld_d    = b_vld_q;
    b_tag_d    = b_tag_q;
    b_dat_d    = b_dat_q;

    // just_q marks the IDLE cycle right after an ack; last_b_q names who got it.
    elig_a   = bus.areq && !(just_q && !last_b_q);
    elig_b   = bus.breq && !(just_q && last_b_q);
    pick_b   = elig_b && (!elig_a || !last_b_q);
    sel_addr = pick_b ? bus.baddr : bus.aaddr;
    sel_wr   = !pick_b && bus.awr;
    hit      = (CACHE_EN != 0) && !sel_wr &&
               (pick_b ? (b_vld_q && (b_tag_q == bus.baddr))
                       : (a_vld_q && (a_tag_q == bus.aaddr)));

    case (state_q)
      S_IDLE: begin
        if (elig_a || elig_b) begin
          gnt_b_d = pick_b;
          if (hit) begin
            state_d = S_ACK;
            if (pick_b) begin
              back_d   = 1'b1;
              brdata_d = b_dat_q;
            end else begin
              aack_d   = 1'b1;
              ardata_d = a_dat_q;
            end
          end else begin
            state_d    = S_MEM;
            memreq_d   = 1'b1;
            memaddr_d  = sel_addr;
            memwr_d    = sel_wr;
            memwdata_d = pick_b ? '0 : bus.awdata;
          end
        end
      end

      S_MEM: begin
        if (bus.memack) begin
          state_d  = S_ACK;
          memreq_d = 1'b0;
          memwr_d  = 1'b0;
          if (gnt_b_q) begin
            back_d   = 1'b1;
            brdata_d = bus.memrdata;
            b_vld_d  = 1'b1;
            b_tag_d  = memaddr_q;
            b_dat_d  = bus.memrdata;
          end else if (memwr_q) begin
            // Cache updates use the latched copy so a dropped client cannot corrupt them.
            aack_d  = 1'b1;
            a_vld_d = 1'b1;
            a_tag_d = memaddr_q;
            a_dat_d = memwdata_q;
            if (b_vld_q && (b_tag_q == memaddr_q)) begin
              b_dat_d = memwdata_q;
            end
          end else begin
            aack_d   = 1'b1;
            ardata_d = bus.memrdata;
            a_vld_d  = 1'b1;
            a_tag_d  = memaddr_q;
            a_dat_d  = bus.memrdata;
          end
        end
      end

      S_ACK: begin
        state_d  = S_IDLE;
        last_b_d = gnt_b_q;
        just_d   = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.aack     = aack_q;
  assign bus.ardata   = ardata_q;
  assign bus.back     = back_q;
  assign bus.brdata   = brdata_q;
  assign bus.memreq   = memreq_q;
  assign bus.memaddr  = memaddr_q;
  assign bus.memwr    = memwr_q;
  assign bus.memwdata = memwdata_q;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: behavioural memory with programmable latency,
// client request tasks and hand-computed expectations.
module tb_mem_arb;
  localparam int AW = 20;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;

  mem_arb_if #(.AW(AW), .DW(DW)) bus ();

  mem_arb #(.AW(AW), .DW(DW), .CACHE_EN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory model: latches a request, raises memack for one cycle mem_lat cycles later.
  logic [DW-1:0] mem [256];
  int            mem_lat = 3;
  int            mem_cnt = 0;
  int            mem_txn = 0;
  int            memack_cyc = 0;
  bit            mem_busy = 1'b0;
  logic          last_wr = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA5A50000 + i;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h20] = 32'h11111111;
    bus.memack   = 1'b0;
    bus.memrdata = '0;
    forever begin
      @(negedge clk);
      if (bus.memack) begin
        bus.memack = 1'b0;
        mem_busy   = 1'b0;
      end
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          bus.memack   = 1'b1;
          bus.memrdata = last_wr ? '0 : mem[m_addr[7:0]];
          if (last_wr) mem[m_addr[7:0]] = m_wdata;
          memack_cyc = cyc;
        end
      end else if (bus.memreq && !mem_busy) begin
        mem_busy = 1'b1;
        m_addr   = bus.memaddr;
        m_wdata  = bus.memwdata;
        last_wr  = bus.memwr;
        mem_txn++;
        mem_cnt  = mem_lat;
      end
    end
  end

  int a_acks = 0;
  int b_acks = 0;
  always @(negedge clk) begin
    if (bus.aack) a_acks++;
    if (bus.back) b_acks++;
  end

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_req(input bit pb, input logic [AW-1:0] a, input bit w,
                        input logic [DW-1:0] wd, output logic [DW-1:0] rd,
                        output int req_cyc, output int ack_cyc, output bit ok);
    ok = 1'b0;
    rd = '0;
    ack_cyc = 0;
    @(negedge clk);
    if (pb) begin
      bus.breq  = 1'b1;
      bus.baddr = a;
    end else begin
      bus.areq   = 1'b1;
      bus.aaddr  = a;
      bus.awr    = w;
      bus.awdata = wd;
    end
    req_cyc = cyc;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (pb ? bus.back : bus.aack) begin
        ok      = 1'b1;
        ack_cyc = cyc;
        rd      = pb ? bus.brdata : bus.ardata;
        break;
      end
    end
    bus.areq = 1'b0;
    bus.breq = 1'b0;
  endtask

  logic [DW-1:0] rd;
  int rc, ac, t0, a0, b0;
  bit ok, got_a, got_b, first_b, have_first;

  initial begin
    rst        = 1'b1;
    bus.areq   = 1'b0;
    bus.aaddr  = '0;
    bus.awr    = 1'b0;
    bus.awdata = '0;
    bus.breq   = 1'b0;
    bus.baddr  = '0;

    settle(3);
    check("rst_aack", bus.aack, 0);
    check("rst_back", bus.back, 0);
    check("rst_memreq", bus.memreq, 0);
    check("rst_memwr", bus.memwr, 0);
    check("rst_ardata", bus.ardata, 0);
    check("rst_brdata", bus.brdata, 0);
    check("rst_memaddr", bus.memaddr, 0);
    check("rst_memwdata", bus.memwdata, 0);
    @(negedge clk);
    rst = 1'b0;

    // Simultaneous requests right after reset: B wins the first tie.
    t0 = mem_txn; a0 = a_acks; b0 = b_acks;
    got_a = 0; got_b = 0; first_b = 0; have_first = 0;
    @(negedge clk);
    bus.areq = 1'b1; bus.aaddr = 20'h00030; bus.awr = 1'b0;
    bus.breq = 1'b1; bus.baddr = 20'h00040;
    for (int i = 0; i < 100 && !(got_a && got_b); i++) begin
      @(negedge clk);
      if (bus.aack && !got_a) begin
        got_a = 1; bus.areq = 1'b0;
        if (!have_first) begin have_first = 1; first_b = 0; end
      end
      if (bus.back && !got_b) begin
        got_b = 1; bus.breq = 1'b0;
        if (!have_first) begin have_first = 1; first_b = 1; end
      end
    end
    bus.areq = 1'b0; bus.breq = 1'b0;
    check("tie_a_acked", got_a, 1);
    check("tie_b_acked", got_b, 1);
    check("tie_b_first", first_b, 1);
    settle(4);
    check("tie_memtxn", mem_txn - t0, 2);
    check("tie_a_ack_count", a_acks - a0, 1);
    check("tie_b_ack_count", b_acks - b0, 1);

    // A read miss 0x10, memory latency 3.
    mem_lat = 3; t0 = mem_txn;
    do_req(0, 20'h00010, 0, '0, rd, rc, ac, ok);
    check("miss_ack_seen", ok, 1);
    check("miss_rdata", rd, 32'hDEADBEEF);
    check("miss_ack_after_memack", ac - memack_cyc, 1);
    settle(2);
    check("miss_memtxn", mem_txn - t0, 1);
    check("miss_memwr", last_wr, 0);

    // Repeat read of 0x10 hits.
    t0 = mem_txn;
    do_req(0, 20'h00010, 0, '0, rd, rc, ac, ok);
    check("hit_ack_seen", ok, 1);
    check("hit_latency", ac - rc, 1);
    check("hit_rdata", rd, 32'hDEADBEEF);
    settle(2);
    check("hit_memtxn", mem_txn - t0, 0);

    // B caches 0x20, A writes it, B re-read hits with A's data.
    t0 = mem_txn;
    do_req(1, 20'h00020, 0, '0, rd, rc, ac, ok);
    check("b_miss_ack_seen", ok, 1);
    check("b_miss_rdata", rd, 32'h11111111);
    settle(1);
    check("b_miss_memtxn", mem_txn - t0, 1);
    t0 = mem_txn;
    do_req(0, 20'h00020, 1, 32'h22222222, rd, rc, ac, ok);
    check("a_wr_ack_seen", ok, 1);
    settle(1);
    check("a_wr_memtxn", mem_txn - t0, 1);
    check("a_wr_memwr", last_wr, 1);
    check("a_wr_mem_data", mem[8'h20], 32'h22222222);
    t0 = mem_txn;
    do_req(1, 20'h00020, 0, '0, rd, rc, ac, ok);
    check("b_hit_ack_seen", ok, 1);
    check("b_hit_latency", ac - rc, 1);
    check("b_hit_rdata", rd, 32'h22222222);
    settle(2);
    check("b_hit_memtxn", mem_txn - t0, 0);

    // areq held 10 cycles across its ack: one ack, one memory transaction.
    mem_lat = 7; t0 = mem_txn; a0 = a_acks;
    @(negedge clk);
    bus.areq = 1'b1; bus.aaddr = 20'h00060; bus.awr = 1'b0;
    repeat (10) @(negedge clk);
    bus.areq = 1'b0;
    settle(6);
    check("hold_a_ack_count", a_acks - a0, 1);
    check("hold_memtxn", mem_txn - t0, 1);

    // Reset during MEM; memack lands two cycles after reset and is ignored.
    mem_lat = 4; t0 = mem_txn; a0 = a_acks; b0 = b_acks;
    @(negedge clk);
    bus.areq = 1'b1; bus.aaddr = 20'h00070; bus.awr = 1'b0;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (bus.memreq) ok = 1;
    end
    check("rstmem_memreq_seen", ok, 1);
    @(negedge clk);
    rst = 1'b1; bus.areq = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rstmem_memreq_low", bus.memreq, 0);
    settle(6);
    check("rstmem_no_aack", a_acks - a0, 0);
    check("rstmem_no_back", b_acks - b0, 0);
    check("rstmem_memtxn", mem_txn - t0, 1);
    check("rstmem_memreq_idle", bus.memreq, 0);

    // Caches were cleared: 0x10 misses again and completes.
    mem_lat = 3; t0 = mem_txn;
    do_req(0, 20'h00010, 0, '0, rd, rc, ac, ok);
    check("post_rst_ack_seen", ok, 1);
    check("post_rst_rdata", rd, 32'hDEADBEEF);
    settle(2);
    check("post_rst_memtxn", mem_txn - t0, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
